// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared control types and constants for the decode/execute boundary
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALU_OP_WIDTH   = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        logic    memtoreg;
        logic    alusrc;
        logic    regdst;
        alu_op_t alu_op;
    } ctrl_t;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;
    localparam ctrl_t                     CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard check between decode and EX slots
module load_use_detect
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_WIDTH
) (
    input  logic                  dec_valid,
    input  logic                  dec_uses_rs,
    input  logic                  dec_uses_rt,
    input  logic [REG_ADDR_W-1:0] dec_rs,
    input  logic [REG_ADDR_W-1:0] dec_rt,
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_wreg,
    output logic                  load_use
);

    logic rs_hit;
    logic rt_hit;

    // A load into $0 produces nothing to wait for, so it never stalls.
    always_comb begin
        rs_hit   = dec_uses_rs && (dec_rs == ex_wreg);
        rt_hit   = dec_uses_rt && (dec_rt == ex_wreg);
        load_use = dec_valid && ex_valid && ex_memread &&
                   (ex_wreg != REG_ADDR_W'(REG_ZERO)) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/dec_ex_stage.sv
// rtl/dec_ex_stage.sv - decode->execute pipeline register with load-use bubble, flush and WB bypass
module dec_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = DATA_WIDTH,
    parameter int REG_ADDR_W = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_valid,
    input  logic [DATA_W-1:0]     dec_pc,
    input  logic [REG_ADDR_W-1:0] dec_rs,
    input  logic [REG_ADDR_W-1:0] dec_rt,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_uses_rs,
    input  logic                  dec_uses_rt,
    input  logic [DATA_W-1:0]     dec_rs_data,
    input  logic [DATA_W-1:0]     dec_rt_data,
    input  logic [DATA_W-1:0]     dec_imm,
    input  ctrl_t                 dec_ctrl,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  mem_stall,
    input  logic                  flush,
    output logic                  stall_dec,
    output logic                  dec_ex_valid,
    output logic [DATA_W-1:0]     dec_ex_pc,
    output logic [REG_ADDR_W-1:0] dec_ex_rs,
    output logic [REG_ADDR_W-1:0] dec_ex_rt,
    output logic [REG_ADDR_W-1:0] dec_ex_wreg,
    output logic [DATA_W-1:0]     dec_ex_rs_data,
    output logic [DATA_W-1:0]     dec_ex_rt_data,
    output logic [DATA_W-1:0]     dec_ex_imm,
    output ctrl_t                 dec_ex_ctrl
);

    logic                  load_use;
    logic                  insert_bubble;
    logic                  wb_live;
    logic [DATA_W-1:0]     rs_data_byp;
    logic [DATA_W-1:0]     rt_data_byp;
    logic [REG_ADDR_W-1:0] wreg_next;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .dec_valid   (dec_valid),
        .dec_uses_rs (dec_uses_rs),
        .dec_uses_rt (dec_uses_rt),
        .dec_rs      (dec_rs),
        .dec_rt      (dec_rt),
        .ex_valid    (dec_ex_valid),
        .ex_memread  (dec_ex_ctrl.memread),
        .ex_wreg     (dec_ex_wreg),
        .load_use    (load_use)
    );

    // Flush kills the decode slot, so holding fetch would only delay the redirect.
    assign stall_dec     = !reset && !flush && (load_use || mem_stall);
    assign insert_bubble = flush || (!mem_stall && (load_use || !dec_valid));

    // The regfile read this cycle misses a same-cycle WB write; patch it here.
    always_comb begin
        wb_live     = wb_regwrite && (wb_rd != REG_ADDR_W'(REG_ZERO));
        rs_data_byp = (wb_live && (wb_rd == dec_rs)) ? wb_data : dec_rs_data;
        rt_data_byp = (wb_live && (wb_rd == dec_rt)) ? wb_data : dec_rt_data;
        wreg_next   = dec_ctrl.regdst ? dec_rd : dec_rt;
    end

    always_ff @(posedge clk) begin
        if (reset || insert_bubble) begin
            dec_ex_valid   <= 1'b0;
            dec_ex_pc      <= '0;
            dec_ex_rs      <= '0;
            dec_ex_rt      <= '0;
            dec_ex_wreg    <= '0;
            dec_ex_rs_data <= '0;
            dec_ex_rt_data <= '0;
            dec_ex_imm     <= '0;
            dec_ex_ctrl    <= CTRL_NOP;
        end else if (!mem_stall) begin
            dec_ex_valid   <= 1'b1;
            dec_ex_pc      <= dec_pc;
            dec_ex_rs      <= dec_rs;
            dec_ex_rt      <= dec_rt;
            dec_ex_wreg    <= wreg_next;
            dec_ex_rs_data <= rs_data_byp;
            dec_ex_rt_data <= rt_data_byp;
            dec_ex_imm     <= dec_imm;
            dec_ex_ctrl    <= dec_ctrl;
        end
    end

endmodule

// File: tb/tb_dec_ex_stage.sv
// tb/tb_dec_ex_stage.sv - scoreboard bench for dec_ex_stage with directed hazard vectors
module tb_dec_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [4:0]  dec_rs, dec_rt, dec_rd;
    logic        dec_uses_rs, dec_uses_rt;
    logic [31:0] dec_rs_data, dec_rt_data, dec_imm;
    ctrl_t       dec_ctrl;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_stall, flush;
    logic        stall_dec;
    logic        dec_ex_valid;
    logic [31:0] dec_ex_pc;
    logic [4:0]  dec_ex_rs, dec_ex_rt, dec_ex_wreg;
    logic [31:0] dec_ex_rs_data, dec_ex_rt_data, dec_ex_imm;
    ctrl_t       dec_ex_ctrl;

    always #5 clk = ~clk;

    dec_ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_rs         (dec_rs),
        .dec_rt         (dec_rt),
        .dec_rd         (dec_rd),
        .dec_uses_rs    (dec_uses_rs),
        .dec_uses_rt    (dec_uses_rt),
        .dec_rs_data    (dec_rs_data),
        .dec_rt_data    (dec_rt_data),
        .dec_imm        (dec_imm),
        .dec_ctrl       (dec_ctrl),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .mem_stall      (mem_stall),
        .flush          (flush),
        .stall_dec      (stall_dec),
        .dec_ex_valid   (dec_ex_valid),
        .dec_ex_pc      (dec_ex_pc),
        .dec_ex_rs      (dec_ex_rs),
        .dec_ex_rt      (dec_ex_rt),
        .dec_ex_wreg    (dec_ex_wreg),
        .dec_ex_rs_data (dec_ex_rs_data),
        .dec_ex_rt_data (dec_ex_rt_data),
        .dec_ex_imm     (dec_ex_imm),
        .dec_ex_ctrl    (dec_ex_ctrl)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd;
        logic        uses_rs, uses_rt;
        logic [31:0] rs_data, rt_data, imm;
        ctrl_t       ctrl;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt, wreg;
        logic [31:0] rs_data, rt_data, imm;
        ctrl_t       ctrl;
    } ex_t;

    typedef struct {
        int    due;
        bit    is_stall;
        logic  stall;
        ex_t   ex;
        string name;
    } exp_t;

    localparam int K_BUB  = 0;
    localparam int K_HOLD = 1;
    localparam int K_LOAD = 2;

    localparam ctrl_t C_LW = '{regwrite:1'b1, memread:1'b1, memwrite:1'b0, memtoreg:1'b1,
                               alusrc:1'b1, regdst:1'b0, alu_op:ALU_ADD};
    localparam ctrl_t C_R  = '{regwrite:1'b1, memread:1'b0, memwrite:1'b0, memtoreg:1'b0,
                               alusrc:1'b0, regdst:1'b1, alu_op:ALU_ADD};
    localparam ctrl_t C_I  = '{regwrite:1'b1, memread:1'b0, memwrite:1'b0, memtoreg:1'b0,
                               alusrc:1'b1, regdst:1'b0, alu_op:ALU_OR};

    exp_t q[$];
    ex_t  last_exp;
    int   cnt = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clk) cnt <= cnt + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cnt) begin
            exp_t e;
            ex_t  act;
            e = q.pop_front();
            act.valid   = dec_ex_valid;
            act.pc      = dec_ex_pc;
            act.rs      = dec_ex_rs;
            act.rt      = dec_ex_rt;
            act.wreg    = dec_ex_wreg;
            act.rs_data = dec_ex_rs_data;
            act.rt_data = dec_ex_rt_data;
            act.imm     = dec_ex_imm;
            act.ctrl    = dec_ex_ctrl;
            compared++;
            if (e.is_stall) begin
                if (stall_dec !== e.stall) begin
                    mismatched++;
                    $display("FAIL %s: stall_dec got %b expected %b", e.name, stall_dec, e.stall);
                end
            end else if (act !== e.ex) begin
                mismatched++;
                $display("FAIL %s: ex got %h expected %h", e.name, act, e.ex);
            end
        end
    end

    function automatic dec_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic urs,
                                input logic urt, input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [31:0] imm, input ctrl_t c);
        dec_t d;
        d.valid = v; d.pc = pc; d.rs = rs; d.rt = rt; d.rd = rd;
        d.uses_rs = urs; d.uses_rt = urt;
        d.rs_data = rsd; d.rt_data = rtd; d.imm = imm; d.ctrl = c;
        return d;
    endfunction

    task automatic step(input string name, input logic rst, input dec_t d,
                        input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                        input logic ms, input logic fl, input logic exp_stall, input int kind,
                        input logic [4:0] ewreg, input logic [31:0] ersd, input logic [31:0] ertd);
        exp_t e;
        ex_t  x;
        @(posedge clk);
        #1;
        reset = rst;
        dec_valid = d.valid; dec_pc = d.pc; dec_rs = d.rs; dec_rt = d.rt; dec_rd = d.rd;
        dec_uses_rs = d.uses_rs; dec_uses_rt = d.uses_rt;
        dec_rs_data = d.rs_data; dec_rt_data = d.rt_data; dec_imm = d.imm; dec_ctrl = d.ctrl;
        wb_regwrite = wbw; wb_rd = wbr; wb_data = wbd;
        mem_stall = ms; flush = fl;
        e.due = cnt; e.is_stall = 1'b1; e.stall = exp_stall; e.ex = '0;
        e.name = {name, "/stall"};
        q.push_back(e);
        x = '0;
        if (kind == K_HOLD) begin
            x = last_exp;
        end else if (kind == K_LOAD) begin
            x.valid = 1'b1; x.pc = d.pc; x.rs = d.rs; x.rt = d.rt; x.wreg = ewreg;
            x.rs_data = ersd; x.rt_data = ertd; x.imm = d.imm; x.ctrl = d.ctrl;
        end
        e.due = cnt + 1; e.is_stall = 1'b0; e.stall = 1'b0; e.ex = x;
        e.name = {name, "/ex"};
        q.push_back(e);
        last_exp = x;
    endtask

    dec_t lw8, add9, lw0, add0, addi8, byp5, byp0, byp_rt, inv8, rnd;

    initial begin
        lw8    = mk(1, 32'h100, 5'd2, 5'd8, 5'd0, 1, 0, 32'h1000, 32'h55, 32'h4, C_LW);
        add9   = mk(1, 32'h104, 5'd8, 5'd3, 5'd9, 1, 1, 32'h11, 32'h22, 32'h0, C_R);
        lw0    = mk(1, 32'h108, 5'd2, 5'd0, 5'd0, 1, 0, 32'h1000, 32'h0, 32'h8, C_LW);
        add0   = mk(1, 32'h10C, 5'd0, 5'd3, 5'd9, 1, 1, 32'h0, 32'h22, 32'h0, C_R);
        addi8  = mk(1, 32'h110, 5'd4, 5'd8, 5'd0, 1, 0, 32'h44, 32'h77, 32'h10, C_I);
        byp5   = mk(1, 32'h114, 5'd5, 5'd5, 5'd7, 1, 1, 32'h0, 32'h0, 32'h0, C_R);
        byp0   = mk(1, 32'h118, 5'd0, 5'd0, 5'd7, 1, 1, 32'h123, 32'h456, 32'h0, C_R);
        byp_rt = mk(1, 32'h11C, 5'd6, 5'd5, 5'd7, 1, 1, 32'h66, 32'h0, 32'h0, C_R);
        inv8   = mk(0, 32'h200, 5'd8, 5'd8, 5'd9, 1, 1, 32'hAA, 32'hBB, 32'hCC, C_R);

        for (int i = 0; i < 2; i++) begin
            rnd = mk(1'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                     1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, ctrl_t'($urandom));
            step("reset", 1, rnd, 1'($urandom), 5'($urandom), $urandom, 1, 0, 0, K_BUB, 0, 0, 0);
        end

        step("lw8",        0, lw8,  0, 0, 0, 0, 0, 0, K_LOAD, 5'd8, 32'h1000, 32'h55);
        step("add9_hazard",0, add9, 0, 0, 0, 0, 0, 1, K_BUB,  0, 0, 0);
        step("add9_issue", 0, add9, 0, 0, 0, 0, 0, 0, K_LOAD, 5'd9, 32'h11, 32'h22);

        step("lw0",        0, lw0,  0, 0, 0, 0, 0, 0, K_LOAD, 5'd0, 32'h1000, 32'h0);
        step("add_rs0",    0, add0, 0, 0, 0, 0, 0, 0, K_LOAD, 5'd9, 32'h0, 32'h22);
        step("lw8_b",      0, lw8,  0, 0, 0, 0, 0, 0, K_LOAD, 5'd8, 32'h1000, 32'h55);
        step("addi_rt8",   0, addi8,0, 0, 0, 0, 0, 0, K_LOAD, 5'd8, 32'h44, 32'h77);

        step("wb_byp5",    0, byp5, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, K_LOAD, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF);
        step("wb_rd0",     0, byp0, 1, 5'd0, 32'hDEADBEEF, 0, 0, 0, K_LOAD, 5'd7, 32'h123, 32'h456);
        step("wb_rt_only", 0, byp_rt,1, 5'd5, 32'hCAFEF00D, 0, 0, 0, K_LOAD, 5'd7, 32'h66, 32'hCAFEF00D);

        step("lw8_c",      0, lw8,  0, 0, 0, 0, 0, 0, K_LOAD, 5'd8, 32'h1000, 32'h55);
        for (int i = 0; i < 3; i++)
            step("memstall",  0, add9, 0, 0, 0, 1, 0, 1, K_HOLD, 0, 0, 0);
        step("lu_release", 0, add9, 0, 0, 0, 0, 0, 1, K_BUB,  0, 0, 0);
        step("post_bub_byp",0, add9, 1, 5'd8, 32'h8888, 0, 0, 0, K_LOAD, 5'd9, 32'h8888, 32'h22);

        step("lw8_d",      0, lw8,  0, 0, 0, 0, 0, 0, K_LOAD, 5'd8, 32'h1000, 32'h55);
        step("flush_all",  0, add9, 0, 0, 0, 1, 1, 0, K_BUB,  0, 0, 0);
        step("after_flush",0, add9, 0, 0, 0, 0, 0, 0, K_LOAD, 5'd9, 32'h11, 32'h22);

        step("lw8_e",      0, lw8,  0, 0, 0, 0, 0, 0, K_LOAD, 5'd8, 32'h1000, 32'h55);
        step("invalid",    0, inv8, 0, 0, 0, 0, 0, 0, K_BUB,  0, 0, 0);
        step("add9_after_inv",0, add9,0, 0, 0, 0, 0, 0, K_LOAD, 5'd9, 32'h11, 32'h22);

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
